// File: rtl/ahb_lite_mem_slave_if.sv
// ahb_lite_mem_slave_if: AHB-Lite bus bundle between one master and the memory slave
// master drives Hsel/Haddr/Htrans/Hwrite/Hsize/Hburst/Hprot/Hmastlock/Hwdata and the global Hready_in;
// slave drives Hready_out/Hresp/Hrdata.
interface ahb_lite_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  Hsel;
  logic [ADDR_WIDTH-1:0] Haddr;
  logic [1:0]            Htrans;
  logic                  Hwrite;
  logic [2:0]            Hsize;
  logic [2:0]            Hburst;
  logic [3:0]            Hprot;
  logic                  Hmastlock;
  logic [DATA_WIDTH-1:0] Hwdata;
  logic                  Hready_in;
  logic                  Hready_out;
  logic                  Hresp;
  logic [DATA_WIDTH-1:0] Hrdata;
  modport master (
    output Hsel, Haddr, Htrans, Hwrite, Hsize, Hburst, Hprot, Hmastlock, Hwdata, Hready_in,
    input  Hready_out, Hresp, Hrdata
  );
  modport slave (
    input  Hsel, Haddr, Htrans, Hwrite, Hsize, Hburst, Hprot, Hmastlock, Hwdata, Hready_in,
    output Hready_out, Hresp, Hrdata
  );
endinterface

// File: rtl/ahb_lite_mem_slave.sv
// ahb_lite_mem_slave: AHB-Lite word RAM responder with programmable wait states and two-cycle ERROR
// hclk/hreset: clock and synchronous active-high reset; wait_cycles: wait states per transfer (clamped to WAIT_MAX);
// bus: slave modport carrying the AHB-Lite address/data phase signals.
module ahb_lite_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int WAIT_MAX   = 7
) (
  input logic                 hclk,
  input logic                 hreset,
  input logic [2:0]           wait_cycles,
  ahb_lite_mem_slave_if.slave bus
);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(MEM_DEPTH * 4);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_XFER, S_ERR1, S_ERR2} state_t;
  state_t                state, state_d;
  logic [IW+1:0]         addr_q;
  logic [1:0]            size_q;
  logic                  write_q;
  logic [2:0]            cnt;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  open, accept, bad;
  logic [2:0]            wait_c;
  logic [3:0]            be;
  logic                  unused_ok;
  assign unused_ok = ^{bus.Htrans[0], bus.Hburst, bus.Hprot, bus.Hmastlock};
  // A new address phase can only be taken in states where this slave drives ready high.
  always_comb begin
    open = state == S_IDLE || state == S_XFER || state == S_ERR2;
    accept = open && bus.Hsel && bus.Hready_in && bus.Htrans[1];
    bad = bus.Haddr >= LIMIT || bus.Hsize > 3'd2 || (bus.Hsize == 3'd1 && bus.Haddr[0])
       || (bus.Hsize == 3'd2 && bus.Haddr[1:0] != 2'b00);
    wait_c = 32'(wait_cycles) > WAIT_MAX ? 3'(WAIT_MAX) : wait_cycles;
    state_d = state;
    state_d = state == S_WAIT ? (cnt == 3'd1 ? S_XFER : S_WAIT)
            : state == S_ERR1 ? S_ERR2
            : !accept ? S_IDLE : bad ? S_ERR1 : wait_c == 3'd0 ? S_XFER : S_WAIT;
    bus.Hready_out = !(state == S_WAIT || state == S_ERR1);
    bus.Hresp = state == S_ERR1 || state == S_ERR2;
    bus.Hrdata = (state == S_XFER && !write_q) ? mem[addr_q[IW+1:2]] : '0;
    be = size_q == 2'd0 ? 4'b0001 << addr_q[1:0] : size_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  end
  always_ff @(posedge hclk) begin
    state <= hreset ? S_IDLE : state_d;
    cnt <= accept ? wait_c : state == S_WAIT ? cnt - 3'd1 : cnt;
    if (accept) begin
      addr_q <= bus.Haddr[IW+1:0];
      size_q <= bus.Hsize[1:0];
      write_q <= bus.Hwrite;
    end
  end
  // RAM is never cleared; a reset in the completing cycle suppresses the write.
  always_ff @(posedge hclk)
    if (!hreset && state == S_XFER && write_q)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr_q[IW+1:2]][8*i +: 8] <= bus.Hwdata[8*i +: 8];
endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// tb_ahb_lite_mem_slave: randomized self-checking bench against a byte-addressed memory model
module tb_ahb_lite_mem_slave;
  logic hclk = 0;
  logic hreset = 1;
  logic [2:0] wait_cycles = 0;
  int errs = 0;
  int checks = 0;
  logic [7:0] m [1024];
  ahb_lite_mem_slave_if bus ();
  assign bus.Hready_in = bus.Hready_out;
  ahb_lite_mem_slave dut (.hclk(hclk), .hreset(hreset), .wait_cycles(wait_cycles), .bus(bus));
  always #5 hclk = ~hclk;
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, want finish before 2ms");
    $fatal(1);
  end
  function automatic logic [31:0] mrd(input int a);
    int w;
    w = a & ~3;
    return {m[w+3], m[w+2], m[w+1], m[w]};
  endfunction
  task automatic mwr(input int a, input int sz, input logic [31:0] wd);
    for (int k = 0; k < (1 << sz); k++) m[a+k] = wd[8*((a+k)%4) +: 8];
  endtask
  function automatic logic is_err(input int a, input int sz);
    return a >= 1024 || sz > 2 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
  endfunction
  // One non-pipelined transfer; reports ready-low cycle count, Hresp seen while low, and final-cycle Hresp/Hrdata.
  task automatic xfer(input int a, input int sz, input logic wr, input logic [31:0] wd,
                      output int lo, output logic rlo, output logic rlast, output logic [31:0] rd);
    @(negedge hclk);
    bus.Hsel = 1; bus.Haddr = 32'(a); bus.Hsize = 3'(sz); bus.Hwrite = wr; bus.Htrans = 2'b10;
    @(negedge hclk);
    bus.Hsel = 0; bus.Htrans = 2'b00; bus.Hwdata = wd;
    lo = 0; rlo = 0;
    while (bus.Hready_out !== 1'b1 && lo < 20) begin
      rlo |= bus.Hresp;
      lo++;
      @(negedge hclk);
    end
    if (lo == 20) lo = -1;
    rlast = bus.Hresp;
    rd = bus.Hrdata;
  endtask
  task automatic test_reset();
    hreset = 1;
    repeat (3) @(negedge hclk);
    checks++; if (bus.Hready_out !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", bus.Hready_out); end
    checks++; if (bus.Hresp !== 1'b0) begin errs++; $display("FAIL reset_resp: got %b want 0", bus.Hresp); end
    checks++; if (bus.Hrdata !== 32'h0) begin errs++; $display("FAIL reset_rdata: got %h want 0", bus.Hrdata); end
    hreset = 0;
    bus.Hsel = 1; bus.Htrans = 2'b00; bus.Haddr = 32'h10;
    @(negedge hclk);
    bus.Htrans = 2'b01;
    @(negedge hclk);
    checks++; if ({bus.Hready_out, bus.Hresp} !== 2'b10) begin errs++; $display("FAIL idle_busy_okay: got ready/resp %b want 10", {bus.Hready_out, bus.Hresp}); end
    bus.Hsel = 0; bus.Htrans = 2'b00;
    @(negedge hclk);
    checks++; if ({bus.Hready_out, bus.Hresp} !== 2'b10) begin errs++; $display("FAIL unselected_okay: got ready/resp %b want 10", {bus.Hready_out, bus.Hresp}); end
  endtask
  task automatic test_fill();
    int lo, sum;
    logic rlo, rl, any;
    logic [31:0] rd, d;
    sum = 0; any = 0;
    wait_cycles = 0;
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      xfer(i * 4, 2, 1, d, lo, rlo, rl, rd);
      mwr(i * 4, 2, d);
      sum += (lo < 0) ? 100 : lo;
      any |= rl;
    end
    checks++; if (sum != 0 || any !== 1'b0) begin errs++; $display("FAIL fill_okay: got wait sum %0d resp %b want 0 0", sum, any); end
  endtask
  task automatic test_basic();
    int lo;
    logic rlo, rl;
    logic [31:0] rd;
    wait_cycles = 0;
    xfer('h10, 2, 1, 32'hDEADBEEF, lo, rlo, rl, rd);
    mwr('h10, 2, 32'hDEADBEEF);
    checks++; if (lo != 0 || rl !== 1'b0) begin errs++; $display("FAIL basic_write: got lo %0d resp %b want 0 0", lo, rl); end
    xfer('h10, 2, 0, $urandom, lo, rlo, rl, rd);
    checks++; if (lo != 0 || rl !== 1'b0) begin errs++; $display("FAIL basic_read_okay: got lo %0d resp %b want 0 0", lo, rl); end
    checks++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL basic_read_data: got %h want deadbeef", rd); end
  endtask
  task automatic test_wait();
    int lo;
    logic rlo, rl;
    logic [31:0] rd;
    wait_cycles = 3;
    xfer('h0, 2, 0, 0, lo, rlo, rl, rd);
    checks++; if (lo != 3) begin errs++; $display("FAIL wait3_low_cycles: got %0d want 3", lo); end
    checks++; if (rlo !== 1'b0 || rl !== 1'b0) begin errs++; $display("FAIL wait3_resp: got %b%b want 00", rlo, rl); end
    checks++; if (rd !== mrd(0)) begin errs++; $display("FAIL wait3_data: got %h want %h", rd, mrd(0)); end
  endtask
  task automatic test_lanes();
    int lo;
    logic rlo, rl;
    logic [31:0] rd, d;
    wait_cycles = 0;
    xfer('h20, 2, 1, 32'h11223344, lo, rlo, rl, rd);
    mwr('h20, 2, 32'h11223344);
    d = ($urandom & 32'hFFFF00FF) | 32'h0000AA00;
    xfer('h21, 0, 1, d, lo, rlo, rl, rd);
    mwr('h21, 0, d);
    d = ($urandom & 32'h0000FFFF) | 32'h55660000;
    xfer('h22, 1, 1, d, lo, rlo, rl, rd);
    mwr('h22, 1, d);
    xfer('h20, 2, 0, 0, lo, rlo, rl, rd);
    checks++; if (rd !== 32'h5566AA44) begin errs++; $display("FAIL lanes_merge: got %h want 5566aa44", rd); end
    checks++; if (rd !== mrd('h20)) begin errs++; $display("FAIL lanes_model: got %h want %h", rd, mrd('h20)); end
  endtask
  task automatic test_errors();
    int ea [5];
    int es [5];
    logic ew [5];
    int ra [3];
    int lo;
    logic rlo, rl;
    logic [31:0] rd;
    ea = '{'h402, 'h03, 'h400, 'h11, 'h08};
    es = '{2, 1, 2, 2, 3};
    ew = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    ra = '{'h0, 'h10, 'h8};
    wait_cycles = 4;
    for (int i = 0; i < 5; i++) begin
      xfer(ea[i], es[i], ew[i], $urandom, lo, rlo, rl, rd);
      checks++; if (lo != 1 || rlo !== 1'b1 || rl !== 1'b1) begin errs++; $display("FAIL error_resp %0d: got lo %0d resp %b/%b want 1 1/1", i, lo, rlo, rl); end
      checks++; if (rd !== 32'h0) begin errs++; $display("FAIL error_rdata %0d: got %h want 0", i, rd); end
    end
    wait_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      xfer(ra[i], 2, 0, 0, lo, rlo, rl, rd);
      checks++; if (rd !== mrd(ra[i])) begin errs++; $display("FAIL error_ram_unchanged %h: got %h want %h", ra[i], rd, mrd(ra[i])); end
    end
  endtask
  task automatic test_back_to_back();
    int a [8];
    logic [31:0] wd [8];
    a = '{'h40, 'h44, 'h48, 'h4C, 'h4C, 'h40, 'h44, 'h48};
    wait_cycles = 0;
    for (int i = 0; i < 8; i++) wd[i] = $urandom;
    for (int i = 0; i <= 8; i++) begin
      @(negedge hclk);
      if (i > 0) begin
        checks++; if ({bus.Hready_out, bus.Hresp} !== 2'b10) begin errs++; $display("FAIL b2b_okay beat %0d: got ready/resp %b want 10", i - 1, {bus.Hready_out, bus.Hresp}); end
        if (i <= 4) begin
          bus.Hwdata = wd[i-1];
          mwr(a[i-1], 2, wd[i-1]);
        end else begin
          checks++; if (bus.Hrdata !== mrd(a[i-1])) begin errs++; $display("FAIL b2b_read %h: got %h want %h", a[i-1], bus.Hrdata, mrd(a[i-1])); end
        end
      end
      if (i < 8) begin
        bus.Hsel = 1; bus.Haddr = 32'(a[i]); bus.Hsize = 3'd2; bus.Hwrite = i < 4; bus.Hburst = 3'b011;
        bus.Htrans = (i == 0 || i == 4) ? 2'b10 : 2'b11;
      end else begin
        bus.Hsel = 0; bus.Htrans = 2'b00; bus.Hburst = 3'b000;
      end
    end
  endtask
  task automatic test_reset_mid();
    int lo;
    logic rlo, rl;
    logic [31:0] rd;
    wait_cycles = 5;
    @(negedge hclk);
    bus.Hsel = 1; bus.Haddr = 32'h80; bus.Hsize = 3'd2; bus.Hwrite = 1; bus.Htrans = 2'b10;
    @(negedge hclk);
    bus.Hsel = 0; bus.Htrans = 2'b00; bus.Hwdata = ~mrd('h80);
    @(negedge hclk);
    checks++; if (bus.Hready_out !== 1'b0) begin errs++; $display("FAIL midreset_waiting: got ready %b want 0", bus.Hready_out); end
    hreset = 1;
    @(negedge hclk);
    checks++; if ({bus.Hready_out, bus.Hresp} !== 2'b10 || bus.Hrdata !== 32'h0) begin errs++; $display("FAIL midreset_idle: got ready/resp %b rdata %h want 10 0", {bus.Hready_out, bus.Hresp}, bus.Hrdata); end
    hreset = 0;
    wait_cycles = 0;
    repeat (8) @(negedge hclk);
    xfer('h80, 2, 0, 0, lo, rlo, rl, rd);
    checks++; if (rd !== mrd('h80)) begin errs++; $display("FAIL midreset_ram_kept: got %h want %h", rd, mrd('h80)); end
  endtask
  task automatic test_random();
    int a, sz, w, lo;
    logic wr, e, rlo, rl;
    logic [31:0] rd, d, exp;
    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 1023));
      sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      if (sz <= 2 && $urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
      wr = 1'($urandom);
      w = $urandom_range(0, 7);
      d = $urandom;
      wait_cycles = 3'(w);
      e = is_err(a, sz);
      exp = (e || wr) ? 32'h0 : mrd(a);
      xfer(a, sz, wr, d, lo, rlo, rl, rd);
      checks++; if (lo != (e ? 1 : w)) begin errs++; $display("FAIL rand_latency a=%h sz=%0d: got %0d want %0d", a, sz, lo, e ? 1 : w); end
      checks++; if (rlo !== e && lo > 0) begin errs++; $display("FAIL rand_resp_wait a=%h: got %b want %b", a, rlo, e); end
      checks++; if (rl !== e) begin errs++; $display("FAIL rand_resp a=%h sz=%0d: got %b want %b", a, sz, rl, e); end
      checks++; if (rd !== exp) begin errs++; $display("FAIL rand_rdata a=%h wr=%b: got %h want %h", a, wr, rd, exp); end
      if (!e && wr) mwr(a, sz, d);
    end
  endtask
  initial begin
    bus.Hsel = 0; bus.Haddr = 0; bus.Htrans = 0; bus.Hwrite = 0; bus.Hsize = 0;
    bus.Hburst = 0; bus.Hprot = 0; bus.Hmastlock = 0; bus.Hwdata = 0;
    test_reset();
    test_fill();
    test_basic();
    test_wait();
    test_lanes();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ahb_lite_mem_slave.md
Name: ahb_lite_mem_slave

Overview:
Synthesizable AHB-Lite responder: the slave end of the bus our AHB UVC drives and monitors. Holds a word-organised on-chip RAM and answers single and burst transfers. Supports a programmable number of wait states and a two-cycle ERROR response. It is the DUT for the UVC master agent and the reference responder for back-to-back (B2B) regressions.

Parameters:
ADDR_WIDTH, 32, Haddr width
DATA_WIDTH, 32, Hwdata/Hrdata width; 32 only in this revision
MEM_DEPTH, 256, RAM depth in DATA_WIDTH words; legal byte range is 0 .. MEM_DEPTH*4-1
WAIT_MAX, 7, maximum value accepted on wait_cycles

Ports:
hclk  in  1  bus clock; all logic on rising edge
hreset  in  1  synchronous, active-high reset
Hsel  in  1  slave select, decoded from Haddr
Haddr  in  ADDR_WIDTH  address-phase address
Htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
Hwrite  in  1  1 = write
Hsize  in  3  transfer size; 0 = byte, 1 = half, 2 = word
Hburst  in  3  accepted but ignored; every beat carries its own address
Hprot  in  4  ignored
Hmastlock  in  1  ignored
Hwdata  in  DATA_WIDTH  data-phase write data
Hready_in  in  1  global HREADY
Hready_out  out  1  slave ready
Hresp  out  1  0 = OKAY, 1 = ERROR
Hrdata  out  DATA_WIDTH  read data
wait_cycles  in  3  wait states inserted per transfer; values above WAIT_MAX are clamped

Behaviour:
- Reset (hreset=1 at a rising edge):
  - state=IDLE, Hready_out=1, Hresp=0, Hrdata=0.
  - RAM contents are not cleared.
  - Reset asserted mid-transfer aborts it; no RAM write occurs.
- Address-phase acceptance (all must hold at a rising edge): Hsel=1, Hready_in=1, Htrans[1]=1.
  - On acceptance, latch Haddr, Hsize, Hwrite and wait_cycles (clamped) into the data-phase registers.
  - IDLE or BUSY with Hsel=1 and Hready_in=1 gives a zero-wait OKAY and latches nothing.
- Error check, evaluated on the latched address-phase values. A transfer is an error if any of:
  - address >= MEM_DEPTH*4;
  - Hsize > 2;
  - misaligned: half-word with addr[0]≠0, or word with addr[1:0]≠0.
- FSM states: IDLE, WAIT, XFER, ERR1, ERR2.
  - IDLE: accepted error transfer → ERR1. Accepted good transfer with wait=0 → XFER. Accepted good transfer with wait>0 → WAIT, counter loaded with wait.
  - WAIT: Hready_out=0, Hresp=0. Counter decrements each cycle; reaching 1 → XFER.
  - XFER: Hready_out=1, Hresp=0; the data phase completes this cycle. A new address phase accepted in the same cycle transitions per the IDLE rules; otherwise → IDLE.
  - ERR1: Hready_out=0, Hresp=1 → ERR2.
  - ERR2: Hready_out=1, Hresp=1. Any address phase presented in this cycle (including a master's IDLE cancel) is evaluated exactly as in IDLE. No RAM access for an error transfer.
- Latency and pipelining:
  - A transfer with wait=N completes N+1 cycles after its address phase; Hready_out is low for exactly N cycles.
  - Back-to-back pipelined transfers with wait=0 sustain one transfer per cycle.
- Write:
  - RAM written at the rising edge ending the XFER cycle, word index addr[ADDR_WIDTH-1:2].
  - Byte enables are little-endian: byte lane = addr[1:0]; half-word = lanes addr[1]*2 +{0,1}; word = all lanes. Unselected lanes are unchanged.
- Read:
  - Hrdata = full RAM word at the latched word index, driven during XFER.
  - Hrdata = 0 in all other states and for writes. The master extracts the byte lanes.
- Write-then-read hazard: a write in XFER at cycle N followed by a read of the same word whose XFER is cycle N+1 returns the new data (RAM write at end of N precedes read in N+1).
- Hsel=0 while idle: Hready_out=1, Hresp=0.

Test Plan:
1. Reset, wait=0; word write 0xDEADBEEF @0x10, then word read @0x10 → Hready_out never low; Hrdata=0xDEADBEEF in the read data phase, Hresp=0.
2. wait=3; NONSEQ read @0x0 → Hready_out low exactly 3 cycles, then high with Hresp=0; total latency 4 cycles.
3. Byte write 0xAA to 0x21, then half-word write 0x5566 to 0x22, over a word preloaded with 0x11223344 → word read @0x20 returns 0x5566AA44.
4. Word read @0x402 (MEM_DEPTH=256, out of range) and half-word read @0x03 (misaligned) → each gets cycle 1 {Hready_out=0, Hresp=1}, cycle 2 {Hready_out=1, Hresp=1}; RAM unchanged.
5. INCR4 burst of word writes @0x40, 0x44, 0x48, 0x4C, wait=0, pipelined → four consecutive OKAY cycles; read-back of all four words matches.
6. hreset asserted during WAIT of a write @0x80 with wait=5 → next cycle Hready_out=1, Hresp=0, state IDLE; word @0x80 retains its old value.
